// File: rtl/top_button_counter_pkg.sv
// Shared constants for the push-button counter: glyphs, digit count, timing.
package top_button_counter_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned DIGIT_IDX_W = $clog2(DIGITS);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Active-low glyphs with dp (bit7) off.
  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;
  localparam int unsigned DEBOUNCE_MS      = 20;
  localparam int unsigned SCAN_MS          = 1;

  function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                               input int unsigned ms);
    return (freq_hz / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_DEFAULT = ms_to_cycles(CLK_FREQ_DEFAULT, DEBOUNCE_MS);
  localparam int unsigned SCAN_DEFAULT     = ms_to_cycles(CLK_FREQ_DEFAULT, SCAN_MS);

  typedef logic [3:0]              bcd_t;
  typedef bcd_t [DIGITS-1:0]       bcd_count_t;

  function automatic logic [7:0] seg_decode(input bcd_t d);
    case (d)
      4'd0:    return SEG_DIGIT[0];
      4'd1:    return SEG_DIGIT[1];
      4'd2:    return SEG_DIGIT[2];
      4'd3:    return SEG_DIGIT[3];
      4'd4:    return SEG_DIGIT[4];
      4'd5:    return SEG_DIGIT[5];
      4'd6:    return SEG_DIGIT[6];
      4'd7:    return SEG_DIGIT[7];
      4'd8:    return SEG_DIGIT[8];
      4'd9:    return SEG_DIGIT[9];
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/top_button_counter_debounce.sv
// Synchronizer, debouncer and press-pulse generator for an active-low button.
module button_debounce
  import top_button_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_stable,
  output logic press_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Accept a new level only after it has held for DEBOUNCE_CYCLES; flag falling edges.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = stable_q & ~stable_d;
  end

  // Synchronizer and debounce state; released (1) is the reset level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign btn_stable  = stable_q;
  assign press_pulse = press_q;

endmodule

// File: rtl/top_button_counter.sv
// Board top: counts debounced button presses and shows them on an 8-digit display.
module top_button_counter
  import top_button_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = CLK_FREQ_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS),
  parameter int unsigned SCAN_CYCLES     = ms_to_cycles(CLK_FREQ_HZ, SCAN_MS)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_in,
  output logic [7:0] segment,
  output logic [7:0] select
);

  localparam int unsigned PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_CYCLES - 1);

  logic btn_stable;
  logic press_pulse;

  bcd_count_t             count_q, count_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic [DIGIT_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]             select_q, select_d;
  logic [7:0]             segment_q, segment_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (button_in),
    .btn_stable (btn_stable),
    .press_pulse(press_pulse)
  );

  // BCD increment with ripple carry; 99999999 rolls over to all zeros.
  always_comb begin
    logic carry;
    count_d = count_q;
    carry   = press_pulse;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[i] == 4'd9) begin
          count_d[i] = 4'd0;
        end else begin
          count_d[i] = count_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // Scan prescaler and digit index, plus the registered display drive.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 1'b1;
    end
    select_d  = ~(8'b1 << idx_q);
    segment_d = seg_decode(count_q[idx_q]);
  end

  // All display and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      select_q  <= 8'hFE;
      segment_q <= 8'hC0;
    end else begin
      count_q   <= count_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      select_q  <= select_d;
      segment_q <= segment_d;
    end
  end

  assign select  = select_q;
  assign segment = segment_q;

endmodule

// File: tb/tb_top_button_counter.sv
// Directed bench for top_button_counter with shortened debounce and scan timing.
module tb_top_button_counter;

  localparam int unsigned DEB  = 16;
  localparam int unsigned SCAN = 8;

  logic       clk;
  logic       rst_n;
  logic       button_in;
  logic [7:0] segment;
  logic [7:0] select;

  int checks = 0;
  int errors = 0;

  top_button_counter #(
    .CLK_FREQ_HZ    (800_000),
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_CYCLES    (SCAN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_in(button_in),
    .segment  (segment),
    .select   (select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until digit n is selected and returns its segment value.
  task automatic read_digit(input int unsigned n, output logic [7:0] seg);
    logic [7:0] want;
    bit found;
    want  = ~(8'b1 << n);
    seg   = 'x;
    found = 0;
    for (int i = 0; i < 10 * SCAN && !found; i++) begin
      @(negedge clk);
      if (select === want) begin
        seg   = segment;
        found = 1;
      end
    end
  endtask

  task automatic clean_press();
    @(negedge clk) button_in = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    button_in = 1'b1;
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic hold_level(input logic lvl, input int unsigned n);
    button_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Scaled bouncy press: only the 40-cycle low segment exceeds the window.
  task automatic bouncy_press();
    @(negedge clk);
    hold_level(1'b0, 2);
    hold_level(1'b1, 5);
    hold_level(1'b0, 8);
    hold_level(1'b1, 10);
    hold_level(1'b0, 40);
    hold_level(1'b1, 12);
    hold_level(1'b0, 8);
    hold_level(1'b1, 40);
  endtask

  initial begin
    logic [7:0] seg;
    rst_n     = 1'b0;
    button_in = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_select", {24'h0, select}, 32'hFE);
    check("reset_segment", {24'h0, segment}, 32'hC0);

    // Scan stepping: digit changes appear SCAN+1 edges after release, then every SCAN.
    @(negedge clk) rst_n = 1'b1;
    repeat (SCAN) @(posedge clk);
    #1 check("scan_hold0", {24'h0, select}, 32'hFE);
    for (int unsigned k = 1; k <= 8; k++) begin
      logic [7:0] exp_sel;
      exp_sel = ~(8'b1 << (k % 8));
      if (k == 1) @(posedge clk);
      else repeat (SCAN) @(posedge clk);
      #1;
      check($sformatf("scan_sel%0d", k), {24'h0, select}, {24'h0, exp_sel});
      check($sformatf("scan_seg%0d", k), {24'h0, segment}, 32'hC0);
    end

    // 15-cycle low pulse is one short of the window: no count.
    @(negedge clk) button_in = 1'b0;
    repeat (15) @(negedge clk);
    button_in = 1'b1;
    repeat (30) @(negedge clk);
    check("short_pulse", dut.count_q, 32'h0);

    // 17-cycle low pulse: count steps on the 19th edge after the falling edge.
    @(negedge clk) button_in = 1'b0;
    for (int unsigned e = 1; e <= 19; e++) begin
      @(posedge clk);
      #1;
      if (e == 17) button_in = 1'b1;
      if (e == 18) check("latency_before", dut.count_q, 32'h0);
      if (e == 19) check("latency_after", dut.count_q, 32'h1);
    end
    repeat (40) @(negedge clk);

    bouncy_press();
    check("bouncy_count", dut.count_q, 32'h2);
    read_digit(0, seg);
    check("bouncy_d0", {24'h0, seg}, 32'hA4);
    read_digit(1, seg);
    check("bouncy_d1", {24'h0, seg}, 32'hC0);

    // Carry into digit 1.
    repeat (8) clean_press();
    check("ten_count", dut.count_q, 32'h10);
    read_digit(0, seg);
    check("ten_d0", {24'h0, seg}, 32'hC0);
    read_digit(1, seg);
    check("ten_d1", {24'h0, seg}, 32'hF9);

    // Asynchronous reset while digit 1 is displayed and the button is held.
    button_in = 1'b0;
    read_digit(1, seg);
    check("pre_rst_d1", {24'h0, seg}, 32'hF9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_select", {24'h0, select}, 32'hFE);
    check("async_rst_segment", {24'h0, segment}, 32'hC0);
    check("async_rst_count", dut.count_q, 32'h0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned e = 1; e <= 19; e++) begin
      @(posedge clk);
      #1;
      if (e == 18) check("held_before", dut.count_q, 32'h0);
      if (e == 19) check("held_after", dut.count_q, 32'h1);
    end
    button_in = 1'b1;
    repeat (40) @(negedge clk);
    read_digit(0, seg);
    check("held_d0", {24'h0, seg}, 32'hF9);

    // Roll-over from 99999999.
    @(negedge clk) force dut.count_q = 32'h99999999;
    @(negedge clk) release dut.count_q;
    read_digit(7, seg);
    check("nines_d7", {24'h0, seg}, 32'h90);
    clean_press();
    check("wrap_count", dut.count_q, 32'h0);
    read_digit(0, seg);
    check("wrap_d0", {24'h0, seg}, 32'hC0);
    read_digit(3, seg);
    check("wrap_d3", {24'h0, seg}, 32'hC0);
    read_digit(7, seg);
    check("wrap_d7", {24'h0, seg}, 32'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
